systolic_skew_feeder: RTL

- Front end of the N x N output-stationary systolic matrix-multiply array. Upstream hands it one k-slice per beat: column k of A and row k of B.
- Skews each slice so lane i is delayed i array steps, drives the row-edge a-inputs and column-edge b-inputs of the PE grid, and generates the global PE enable.
- After the last slice it injects zeros until every PE has accumulated its final product, then pulses done.

---
 rtl/systolic_skew_feeder_if.sv | 37 +++
 rtl/systolic_skew_feeder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder_if
// Job control, slice input and array-edge output bundle of the skew feeder.
//   start/k_len     : job start request and inner dimension K
//   busy/done       : job in flight / one-cycle completion pulse
//   in_valid/ready  : slice handshake; in_a_vec = A column k, in_b_vec = B row k
//   out_a/out_b_vec : skewed lanes to PE row edge / PE column edge
//   pe_en           : global PE enable
// master = upstream/array side, slave = feeder side.
// ---------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned N        = 4,
   parameter int unsigned KLEN_W   = 8
);
   logic                  start;
   logic [KLEN_W-1:0]     k_len;
   logic                  busy;
   logic                  in_valid;
   logic                  in_ready;
   logic [N*BITWIDTH-1:0] in_a_vec;
   logic [N*BITWIDTH-1:0] in_b_vec;
   logic [N*BITWIDTH-1:0] out_a_vec;
   logic [N*BITWIDTH-1:0] out_b_vec;
   logic                  pe_en;
   logic                  done;

   modport master (
      output start, k_len, in_valid, in_a_vec, in_b_vec,
      input  busy, in_ready, out_a_vec, out_b_vec, pe_en, done
   );

   modport slave (
      input  start, k_len, in_valid, in_a_vec, in_b_vec,
      output busy, in_ready, out_a_vec, out_b_vec, pe_en, done
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
// Front end of an N x N output-stationary systolic matmul array. Accepts one
// k-slice per beat (column k of A, row k of B), delays lane i by i array
// steps, drives the row/column edges of the PE grid together with the global
// PE enable, then flushes zeros until every PE holds its final sum and
// pulses done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : systolic_skew_feeder_if.slave (job control, slice handshake,
//                skewed lane outputs, pe_en, done)
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned N        = 4,
   parameter int unsigned KLEN_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   systolic_skew_feeder_if.slave bus
);

   localparam int unsigned VEC_W     = N * BITWIDTH;
   localparam int unsigned DRAIN_LEN = 2 * N - 2;
   localparam int unsigned DCNT_W    = $clog2(DRAIN_LEN + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [KLEN_W-1:0]   klen_q, klen_nxt;
   logic [KLEN_W-1:0]   beat_cnt, beat_cnt_nxt;
   logic [DCNT_W-1:0]   drain_cnt, drain_cnt_nxt;
   logic                adv_c;
   logic                clr_c;
   logic                accept_c;
   logic                busy_q, in_ready_q, pe_en_q, done_q;
   logic [VEC_W-1:0]    out_a_q, out_b_q;

   assign accept_c = (state == FEED) && bus.in_valid && in_ready_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, counters and array-advance decode.
   // DRAIN spends one extra non-advancing cycle once the counter is empty so
   // that done lands in the cycle after the last pe_en-high cycle.
   always_comb begin
      state_nxt     = state;
      klen_nxt      = klen_q;
      beat_cnt_nxt  = beat_cnt;
      drain_cnt_nxt = drain_cnt;
      adv_c         = 1'b0;
      clr_c         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && (bus.k_len != '0)) begin
               klen_nxt      = bus.k_len;
               beat_cnt_nxt  = '0;
               drain_cnt_nxt = '0;
               clr_c         = 1'b1;
               state_nxt     = FEED;
            end
         end
         FEED: begin
            if (accept_c) begin
               adv_c = 1'b1;
               // compare against k_len-1 so k_len = 2^KLEN_W-1 never wraps
               if (beat_cnt == (klen_q - KLEN_W'(1))) begin
                  drain_cnt_nxt = DCNT_W'(DRAIN_LEN);
                  state_nxt     = DRAIN;
               end else begin
                  beat_cnt_nxt = beat_cnt + KLEN_W'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_cnt != '0) begin
               adv_c         = 1'b1;
               drain_cnt_nxt = drain_cnt - DCNT_W'(1);
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job length and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         klen_q    <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         klen_q    <= klen_nxt;
         beat_cnt  <= beat_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // Registered control outputs, aligned with the state they describe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         in_ready_q <= 1'b0;
         pe_en_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         busy_q     <= (state_nxt != IDLE);
         in_ready_q <= (state_nxt == FEED);
         pe_en_q    <= adv_c;
         done_q     <= (state_nxt == DONE);
      end
   end

   // Per-lane skew chains: lane i is i+1 registers deep, all stepping together
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [BITWIDTH-1:0] a_stg [0:i];
      logic [BITWIDTH-1:0] b_stg [0:i];
      logic [BITWIDTH-1:0] a_in_c;
      logic [BITWIDTH-1:0] b_in_c;

      // zeros are injected while draining so empty lanes stay MAC-neutral
      assign a_in_c = (state == DRAIN) ? '0 : bus.in_a_vec[i*BITWIDTH +: BITWIDTH];
      assign b_in_c = (state == DRAIN) ? '0 : bus.in_b_vec[i*BITWIDTH +: BITWIDTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= i; s++) begin
               a_stg[s] <= '0;
               b_stg[s] <= '0;
            end
         end else if (clr_c) begin
            for (int s = 0; s <= i; s++) begin
               a_stg[s] <= '0;
               b_stg[s] <= '0;
            end
         end else if (adv_c) begin
            a_stg[0] <= a_in_c;
            b_stg[0] <= b_in_c;
            for (int s = 1; s <= i; s++) begin
               a_stg[s] <= a_stg[s-1];
               b_stg[s] <= b_stg[s-1];
            end
         end
      end

      assign out_a_q[i*BITWIDTH +: BITWIDTH] = a_stg[i];
      assign out_b_q[i*BITWIDTH +: BITWIDTH] = b_stg[i];
   end

   assign bus.busy      = busy_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.pe_en     = pe_en_q;
   assign bus.done      = done_q;
   assign bus.out_a_vec = out_a_q;
   assign bus.out_b_vec = out_b_q;

endmodule
